sad_min_tracker: RTL

- Downstream consumer of the dual-lane small-SAD adder (two 13-bit partial sums per cycle, lanes A and B).
- Accumulates partial sums over the beats of a candidate window into full-window SADs for two horizontally adjacent candidates (col, col+1).
- Keeps a running per-frame minimum with its coordinates and reports best match at frame end.
- Sits between the SAD adder tree and the motion-vector writeback logic.

---
 rtl/sad_min_tracker_pkg.sv | 8 +
 rtl/sad_window_acc.sv | 26 ++
 rtl/sad_min_tracker.sv | 114 +++++++++++
 3 files changed

// File: rtl/sad_min_tracker_pkg.sv
// sad_min_tracker_pkg: shared widths, tracker state encoding and saturation limit.
package sad_min_tracker_pkg;
    localparam int IN_W_D  = 13;
    localparam int ACC_W_D = 21;
    localparam int POS_W_D = 8;
    localparam logic [ACC_W_D-1:0] ACC_MAX = '1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sad_window_acc.sv
// sad_window_acc: single-lane saturating window accumulator; nxt is the sum including the current beat.
module sad_window_acc #(
    parameter int IN_W  = 13,
    parameter int ACC_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             valid,
    input  logic             first,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] nxt
);
    localparam int SW = ACC_W + 1;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    always_comb begin
        sum = {1'b0, acc} + SW'(din);
        nxt = first ? ACC_W'(din) : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (clr) acc <= '0;
        else if (valid) acc <= nxt;
    end
endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: accumulates dual-lane partial SADs into window SADs and tracks the per-frame minimum.
module sad_min_tracker
    import sad_min_tracker_pkg::*;
#(
    parameter int IN_W  = IN_W_D,
    parameter int ACC_W = ACC_W_D,
    parameter int POS_W = POS_W_D
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [IN_W-1:0]  SAD_value_small_A,
    input  logic [IN_W-1:0]  SAD_value_small_B,
    input  logic [POS_W-1:0] in_row,
    input  logic [POS_W-1:0] in_col,
    output logic             busy,
    output logic             result_valid,
    output logic             best_found,
    output logic [ACC_W-1:0] best_sad,
    output logic [POS_W-1:0] best_row,
    output logic [POS_W-1:0] best_col
);
    state_t           state;
    logic             drain_cnt;
    logic             en;
    logic             b_wins;
    logic             cand_valid;
    logic [ACC_W-1:0] nxt_a, nxt_b, cand_a, cand_b, win;
    logic [POS_W-1:0] cand_row, cand_col;

    // frame_start drops any beat presented in the same cycle
    assign en = state == RUN && in_valid && !frame_start;

    sad_window_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_a (
        .clk(Clk), .rst(Rst), .clr(frame_start), .valid(en), .first(in_first),
        .din(SAD_value_small_A), .nxt(nxt_a)
    );
    sad_window_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_b (
        .clk(Clk), .rst(Rst), .clr(frame_start), .valid(en), .first(in_first),
        .din(SAD_value_small_B), .nxt(nxt_b)
    );

    always_comb begin
        b_wins = cand_b < cand_a;
        win    = b_wins ? cand_b : cand_a;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            drain_cnt    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else if (frame_start) begin
            state        <= RUN;
            drain_cnt    <= 1'b0;
            busy         <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            result_valid <= state == DRAIN && !drain_cnt;
            if (state == RUN && frame_end) begin
                state     <= DRAIN;
                drain_cnt <= 1'b1;
            end else if (state == DRAIN) begin
                drain_cnt <= 1'b0;
                if (!drain_cnt) begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cand_valid <= 1'b0;
            cand_a     <= '0;
            cand_b     <= '0;
            cand_row   <= '0;
            cand_col   <= '0;
            best_found <= 1'b0;
            best_sad   <= '1;
            best_row   <= '0;
            best_col   <= '0;
        end else if (frame_start) begin
            cand_valid <= 1'b0;
            best_found <= 1'b0;
            best_sad   <= '1;
            best_row   <= '0;
            best_col   <= '0;
        end else begin
            cand_valid <= en && in_last;
            if (en && in_last) begin
                cand_a   <= nxt_a;
                cand_b   <= nxt_b;
                cand_row <= in_row;
                cand_col <= in_col;
            end
            // strict less-than keeps the earliest window on equal SADs
            if (cand_valid && (!best_found || win < best_sad)) begin
                best_found <= 1'b1;
                best_sad   <= win;
                best_row   <= cand_row;
                best_col   <= b_wins ? cand_col + 1'b1 : cand_col;
            end
        end
    end
endmodule
